// File: rtl/wb_queue.sv
// Writeback queue: merges ALU (A, priority) and load (B) results in order into the register file write port.
// Latency: an entry accepted at edge N can be written to the register file in the cycle after edge N at the earliest.
// Backpressure: readiness comes from the registered count only; a same-cycle drain frees no slot, and B yields to A when one slot is left.
// Optional operand bypass of queued entries is enabled by defining WB_BYPASS_EN.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [AW-1:0]              a_addr,
  input  logic [DW-1:0]              a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [AW-1:0]              b_addr,
  input  logic [DW-1:0]              b_data,
  input  logic                       drain_en,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_wa,
  output logic [DW-1:0]              rf_wd,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [AW-1:0]              q_ra1,
  input  logic [AW-1:0]              q_ra2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              byp1,
  output logic [DW-1:0]              byp2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  // Entry storage is deliberately left out of reset; occupancy alone says what is live.
  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;

  logic          a_acc;
  logic          b_acc;
  logic [PW-1:0] b_slot;
  logic [CW-1:0] count_next;
  entry_t        head_ent;

  // Readiness from registered occupancy; B needs two free slots whenever A is also offering.
  always_comb begin
    a_ready = !rst && (count_q < CW'(DEPTH));
    b_ready = !rst && (a_valid ? (count_q <= CW'(DEPTH - 2)) : (count_q < CW'(DEPTH)));
  end

  // Handshakes and the slot B lands in (behind A when both are accepted).
  always_comb begin
    a_acc  = a_valid && a_ready;
    b_acc  = b_valid && b_ready;
    b_slot = a_acc ? (tail + PW'(1)) : tail;
  end

  // Head entry feeds the register file combinationally; a write happens whenever drain is asked and data exists.
  always_comb begin
    head_ent = mem[head];
    rf_we    = !rst && drain_en && (count_q != '0);
    rf_wa    = head_ent.addr;
    rf_wd    = head_ent.data;
  end

  // Occupancy bookkeeping: up to two accepts and one drain per cycle.
  always_comb begin
    count_next = count_q + CW'(a_acc) + CW'(b_acc) - CW'(rf_we);
  end

  assign count = count_q;

  // Pointer and count state; reset drops every queued entry in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (rf_we) begin
        head <= head + PW'(1);
      end
      tail    <= tail + PW'(a_acc) + PW'(b_acc);
      count_q <= count_next;
    end
  end

  // Entry writes: A at tail, B right after A (or at tail when A is not accepted).
  always_ff @(posedge clk) begin
    if (a_acc) begin
      mem[tail] <= '{addr: a_addr, data: a_data};
    end
    if (b_acc) begin
      mem[b_slot] <= '{addr: b_addr, data: b_data};
    end
  end

`ifdef WB_BYPASS_EN
  // Bypass lookup: scan from oldest to youngest so the youngest match wins; only registered entries count.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = head;
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = '0;
    byp2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!rst && (CW'(i) < count_q)) begin
        if (mem[idx].addr == q_ra1) begin
          hit1 = 1'b1;
          byp1 = mem[idx].data;
        end
        if (mem[idx].addr == q_ra2) begin
          hit2 = 1'b1;
          byp2 = mem[idx].data;
        end
      end
    end
  end
`else
  // Bypass not built: lookup outputs are tied off and the lookup addresses are ignored.
  logic unused_ra;
  assign unused_ra = ^{q_ra1, q_ra2};
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign byp1 = '0;
  assign byp2 = '0;
`endif

endmodule
